key_input_queue: RTL and testbench
==================================

# key_input_queue

Parametrised front end for push-button game input. It debounces `NR_KEYS` raw button lines and resolves simultaneous presses by fixed priority. Each accepted press becomes a 7-bit key code in an internal first-word-fall-through FIFO, with optional typematic auto-repeat while a key is held. It sits between the board buttons and the `KB_IN`/`KB_CH`/`KB_EN` keyboard port of the game core, and replaces the fixed 4-key, single-shot, external-FIFO input path.

## Interface
- `NR_KEYS`, 4: number of button inputs, 1..16.
- `DEBOUNCE_CYCLES`, 100000: stable cycles required for both press and release, ≥ 2.
- `REPEAT_DELAY`, 500000: cycles from the initial push to the first auto-repeat push, ≥ 2.
- `REPEAT_PERIOD`, 150000: cycles between subsequent auto-repeat pushes, ≥ 2.
- `FIFO_DEPTH`, 16: queue entries, power of two, ≥ 2.
- `KEY_CODES`, {7'h41,7'h53,7'h44,7'h57}: packed `NR_KEYS`×7 table. Bits [7i+6:7i] hold the code for key i. The default gives key0=W, key1=D, key2=S, key3=A.
- `FPGA_GlobalClock` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `keys_in` in `NR_KEYS`: raw active-high buttons, asynchronous to the clock.
- `repeat_en` in 1: 1 enables auto-repeat. It is sampled in HELD.
- `rd_en` in 1: pop the head entry. Ignored while `empty`=1.
- `clr_ovf` in 1: clears `overflow`.
- `dout` out 7: head entry, first-word-fall-through. Valid only while `empty`=0.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `count` out clog2(`FIFO_DEPTH`)+1: entries held.
- `overflow` out 1: sticky flag. Set when a push is dropped.
- `push_strobe` out 1: one-cycle pulse on every accepted or dropped push, for debug/LED.

## Operation
- Each key line passes through a 2-flop synchroniser. All logic below uses the synchronised vector `ks`.
- Selection: the highest-indexed asserted bit of `ks` wins. The index is latched as `sel` on the IDLE→DEBOUNCE transition.
- FSM states: IDLE, DEBOUNCE, PUSH, HELD, RELEASE.
  - IDLE: if any `ks` bit is set → DEBOUNCE, latch `sel`, counter=0.
  - DEBOUNCE:
    - If `ks[sel]`=0, or a higher-indexed key is now asserted → IDLE.
    - Else if counter==`DEBOUNCE_CYCLES`-1 → PUSH.
    - Else counter+1.
  - PUSH: one cycle. Writes `KEY_CODES[sel]` and pulses `push_strobe`.
    - If `full` and `rd_en`=0, the write is dropped and `overflow` is set.
    - Then → HELD with repeat counter=0.
  - HELD:
    - If `ks[sel]`=0 → RELEASE, counter=0.
    - Else if `repeat_en`=1 and the repeat counter reaches its limit-1 → PUSH. The limit is `REPEAT_DELAY` before the first repeat of this press and `REPEAT_PERIOD` afterwards.
    - Else the repeat counter increments, but only while `repeat_en`=1.
    - Other keys are ignored until release.
  - RELEASE:
    - If `ks[sel]`=1 → HELD with repeat counter=0. The current limit is kept.
    - Else if counter==`DEBOUNCE_CYCLES`-1 → IDLE.
    - Else counter+1.
- FIFO: circular memory with read and write pointers one bit wider than the address.
  - `count` = wr_ptr − rd_ptr, using modular arithmetic.
  - `empty` = (`count`==0). `full` = (`count`==`FIFO_DEPTH`).
  - Pointers wrap modulo 2×`FIFO_DEPTH`.
  - Simultaneous push and pop:
    - When full: both succeed and `count` is unchanged.
    - When empty: only the push succeeds. The pop is ignored.
- `overflow`: set by a dropped push and cleared by `clr_ovf`. A set in the same cycle as `clr_ovf` takes priority.

## Timing
- Reset (`rst_n`=0, immediate and asynchronous):
  - state=IDLE, all counters 0, synchronisers 0, pointers 0.
  - `empty`=1, `full`=0, `count`=0, `overflow`=0, `push_strobe`=0.
  - FIFO memory is not reset. `dout` is unspecified while `empty`=1.
- Reset asserted mid-press: after deassertion a still-held key is treated as a new press and runs full debounce.
- Press latency: input rises before edge 1 → `empty` falls after edge `DEBOUNCE_CYCLES`+4. That is 2 sync edges, 1 edge to DEBOUNCE, `DEBOUNCE_CYCLES` edges to PUSH, and 1 write edge.
- `push_strobe` is high during the PUSH cycle.
- With `repeat_en`=1 and the key held:
  - The first repeat `push_strobe` occurs `REPEAT_DELAY`+1 cycles after the initial `push_strobe`.
  - Later repeats occur every `REPEAT_PERIOD`+1 cycles.
- Pop: with `rd_en`=1 at an edge while `empty`=0, the next entry appears on `dout` immediately after that edge, with no extra latency.

## Test plan
- `DEBOUNCE_CYCLES`=4, key1 pulsed high for 3 cycles → no push, `empty` stays 1, FSM returns to IDLE.
- `DEBOUNCE_CYCLES`=4, key1 held → `empty` falls after edge 8, `dout`=7'h44, `count`=1. Release, then `rd_en` for 1 cycle → `empty`=1.
- keys 0 and 3 pressed together → one entry, 7'h41. Release key3 while key0 is still held → after release debounce, key0 debounces and pushes 7'h57.
- `REPEAT_DELAY`=6, `REPEAT_PERIOD`=3, `repeat_en`=1, key2 held for 20 cycles after the first push → `push_strobe` gaps of 7, 4, 4, 4; every entry 7'h53. With `repeat_en`=0 → single entry.
- `FIFO_DEPTH`=4 filled to 4, then a fifth push → `overflow`=1, `count`=4, head unchanged. A push coincident with `rd_en` while full → accepted, `count`=4. `clr_ovf` → `overflow`=0.
- Hold key0 and assert `rst_n`=0 mid-DEBOUNCE and again with 2 entries queued → outputs at reset values immediately. After release of reset, a full debounce produces a fresh push.

Source files
------------

// File: rtl/key_input_queue.sv
// key_input_queue: debounced, priority-resolved push-button front end with
// typematic auto-repeat, feeding a first-word-fall-through key-code FIFO.
module key_input_queue #(
   parameter int NR_KEYS = 4,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int REPEAT_DELAY = 500000,
   parameter int REPEAT_PERIOD = 150000,
   parameter int FIFO_DEPTH = 16,
   parameter logic [NR_KEYS*7-1:0] KEY_CODES = {7'h41, 7'h53, 7'h44, 7'h57}
) (
   input  logic FPGA_GlobalClock,
   input  logic rst_n,
   input  logic [NR_KEYS-1:0] keys_in,
   input  logic repeat_en,
   input  logic rd_en,
   input  logic clr_ovf,
   output logic [6:0] dout,
   output logic empty,
   output logic full,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic overflow,
   output logic push_strobe
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int SW = NR_KEYS > 1 ? $clog2(NR_KEYS) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = $clog2(RMAX);
   typedef enum logic [2:0] {IDLE, DEBOUNCE, PUSH, HELD, RELEASE} state_t;
   state_t state;
   logic [NR_KEYS-1:0] s1, ks;
   logic [SW-1:0] sel, top;
   logic higher, rep_done, wr, rd, drop;
   logic [DW-1:0] cnt;
   logic [RW-1:0] rcnt, rlim;
   logic [AW:0] wr_ptr, rd_ptr;
   logic [6:0] mem [FIFO_DEPTH];
   always_comb begin
      top = '0;
      higher = 1'b0;
      for (int i = 0; i < NR_KEYS; i++) begin
         if (ks[i]) top = SW'(i);
         if (ks[i] && i > int'(sel)) higher = 1'b1;
      end
   end
   // first repeat of a press waits the long delay, later ones the short period
   assign rlim = rep_done ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
   always_ff @(posedge FPGA_GlobalClock or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         ks <= '0;
         state <= IDLE;
         sel <= '0;
         cnt <= '0;
         rcnt <= '0;
         rep_done <= 1'b0;
         push_strobe <= 1'b0;
      end else begin
         s1 <= keys_in;
         ks <= s1;
         push_strobe <= 1'b0;
         case (state)
            IDLE:
               if (|ks) begin
                  state <= DEBOUNCE;
                  sel <= top;
                  cnt <= '0;
                  rep_done <= 1'b0;
               end
            DEBOUNCE:
               if (!ks[sel] || higher) state <= IDLE;
               else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                  state <= PUSH;
                  push_strobe <= 1'b1;
               end else cnt <= cnt + DW'(1);
            PUSH: begin
               state <= HELD;
               rcnt <= '0;
            end
            HELD:
               if (!ks[sel]) begin
                  state <= RELEASE;
                  cnt <= '0;
               end else if (repeat_en && rcnt == rlim) begin
                  state <= PUSH;
                  push_strobe <= 1'b1;
                  rep_done <= 1'b1;
               end else if (repeat_en) rcnt <= rcnt + RW'(1);
            RELEASE:
               if (ks[sel]) begin
                  state <= HELD;
                  rcnt <= '0;
               end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) state <= IDLE;
               else cnt <= cnt + DW'(1);
            default: state <= IDLE;
         endcase
      end
   end
   assign wr = state == PUSH;
   // a pop in the same cycle frees the slot, so a full FIFO only drops without rd_en
   assign drop = wr && full && !rd_en;
   assign rd = rd_en && !empty;
   assign count = wr_ptr - rd_ptr;
   assign empty = count == '0;
   assign full = count[AW];
   assign dout = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge FPGA_GlobalClock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr && !drop) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd) rd_ptr <= rd_ptr + (AW+1)'(1);
         overflow <= drop || (overflow && !clr_ovf);
      end
   end
   always_ff @(posedge FPGA_GlobalClock) begin
      if (wr && !drop) mem[wr_ptr[AW-1:0]] <= KEY_CODES[7*int'(sel) +: 7];
   end
endmodule

// File: tb/tb_key_input_queue.sv
// tb_key_input_queue: randomized scoreboard bench; expected push times and codes
// are derived from press latency, priority and repeat arithmetic.
`timescale 1ns/1ps
module tb_key_input_queue;
   localparam int D = 4, RD = 6, RP = 3, DEPTH = 4;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [3:0] keys = '0;
   logic repeat_en = 1'b0, man_rd = 1'b0, mon_rd = 1'b0, clr_ovf = 1'b0, drain = 1'b0;
   logic rd_en;
   logic [6:0] dout;
   logic empty, full, overflow, push_strobe;
   logic [2:0] count;
   int cyc = 0, vectors = 0, miscompares = 0;
   int exp_strobe[$];
   logic [6:0] fifo_m[$];
   logic [6:0] codes [4] = '{7'h57, 7'h44, 7'h53, 7'h41};
   assign rd_en = man_rd | mon_rd;
   key_input_queue #(
      .NR_KEYS(4), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
      .FIFO_DEPTH(DEPTH), .KEY_CODES({7'h41, 7'h53, 7'h44, 7'h57})
   ) dut (
      .FPGA_GlobalClock(clk), .rst_n(rst_n), .keys_in(keys), .repeat_en(repeat_en),
      .rd_en(rd_en), .clr_ovf(clr_ovf), .dout(dout), .empty(empty), .full(full),
      .count(count), .overflow(overflow), .push_strobe(push_strobe)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask
   // scoreboard monitor: pops the FIFO whenever draining and an entry is presented
   always @(negedge clk) begin
      mon_rd = 1'b0;
      if (rst_n && drain && !empty) begin
         if (fifo_m.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL dout: unexpected entry 0x%0h (cycle %0d)", dout, cyc);
         end else check("dout", int'(dout), int'(fifo_m.pop_front()));
         mon_rd = 1'b1;
      end
   end
   always @(negedge clk) begin
      if (push_strobe) begin
         if (exp_strobe.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL push_strobe: unexpected at cycle %0d, expected none", cyc);
         end else check("push_strobe_cycle", cyc, exp_strobe.pop_front());
      end
   end
   // keys applied just after edge t0; mode 0 accepted, 1 dropped, 2 accepted with a coincident pop
   task automatic expect_press(input int w, input logic rep, input int t0, input int hold, input int mode);
      int p, tr;
      p = t0 + D + 3;
      tr = p + hold;
      exp_strobe.push_back(p);
      if (mode == 2) void'(fifo_m.pop_front());
      if (mode != 1) fifo_m.push_back(codes[w]);
      if (rep) for (int q = p + RD + 1; q <= tr + 2; q += RP + 1) begin
         exp_strobe.push_back(q);
         fifo_m.push_back(codes[w]);
      end
      if (mode == 2) begin
         repeat (p - cyc) @(posedge clk);
         #1 man_rd = 1'b1;
         @(posedge clk);
         #1 man_rd = 1'b0;
      end
      repeat (tr - cyc) @(posedge clk);
      #1 keys = '0;
      repeat (D + 8) @(posedge clk);
      #1;
   endtask
   task automatic press(input logic [3:0] mask, input logic rep, input int hold, input int mode);
      int w = 0;
      for (int i = 0; i < 4; i++) if (mask[i]) w = i;
      @(posedge clk);
      #1 keys = mask;
      repeat_en = rep;
      expect_press(w, rep, cyc, hold, mode);
   endtask
   task automatic wait_empty();
      repeat (40) begin
         @(posedge clk);
         #1;
         if (empty) break;
      end
      check("drained_empty", int'(empty), 1);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: no finish within time limit");
      $fatal(1, "watchdog expired");
   end
   initial begin
      int t0, p, tr;
      #12;
      check("reset_empty", int'(empty), 1);
      check("reset_full", int'(full), 0);
      check("reset_count", int'(count), 0);
      check("reset_overflow", int'(overflow), 0);
      check("reset_strobe", int'(push_strobe), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      // short glitch on key1 must not push
      @(posedge clk);
      #1 keys = 4'b0010;
      repeat (3) @(posedge clk);
      #1 keys = '0;
      repeat (20) @(posedge clk);
      #1 check("glitch_empty", int'(empty), 1);
      check("glitch_count", int'(count), 0);
      // key1 held: exact press latency
      keys = 4'b0010;
      t0 = cyc;
      exp_strobe.push_back(t0 + D + 3);
      fifo_m.push_back(codes[1]);
      repeat (D + 3) @(posedge clk);
      #1 check("latency_still_empty", int'(empty), 1);
      @(posedge clk);
      #1 check("latency_empty", int'(empty), 0);
      check("latency_dout", int'(dout), 'h44);
      check("latency_count", int'(count), 1);
      keys = '0;
      repeat (D + 6) @(posedge clk);
      #1 man_rd = 1'b1;
      @(posedge clk);
      #1 man_rd = 1'b0;
      void'(fifo_m.pop_front());
      check("pop_empty", int'(empty), 1);
      // priority: key3 beats key0, then key0 pushes once key3 is released
      drain = 1'b1;
      repeat_en = 1'b0;
      keys = 4'b1001;
      t0 = cyc;
      p = t0 + D + 3;
      tr = p + 3;
      exp_strobe.push_back(p);
      fifo_m.push_back(codes[3]);
      exp_strobe.push_back(tr + 2 * D + 4);
      fifo_m.push_back(codes[0]);
      repeat (tr - cyc) @(posedge clk);
      #1 keys = 4'b0001;
      repeat (2 * D + 8) @(posedge clk);
      #1 keys = '0;
      repeat (D + 8) @(posedge clk);
      // auto-repeat: gaps of RD+1 then RP+1, and a single entry with repeat off
      press(4'b0100, 1'b1, 20, 0);
      press(4'b0100, 1'b0, 20, 0);
      for (int n = 0; n < 25; n++)
         press(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 20), 0);
      wait_empty();
      // fill, overflow, push with coincident pop, clear
      drain = 1'b0;
      press(4'b0001, 1'b0, 2, 0);
      press(4'b0010, 1'b0, 2, 0);
      press(4'b0100, 1'b0, 2, 0);
      press(4'b1000, 1'b0, 2, 0);
      check("fill_count", int'(count), DEPTH);
      check("fill_full", int'(full), 1);
      check("fill_overflow", int'(overflow), 0);
      press(4'b0010, 1'b0, 2, 1);
      check("drop_overflow", int'(overflow), 1);
      check("drop_count", int'(count), DEPTH);
      check("drop_head", int'(dout), int'(fifo_m[0]));
      press(4'b0100, 1'b0, 2, 2);
      check("coincide_count", int'(count), DEPTH);
      check("coincide_head", int'(dout), int'(fifo_m[0]));
      check("coincide_overflow", int'(overflow), 1);
      @(posedge clk);
      #1 clr_ovf = 1'b1;
      @(posedge clk);
      #1 clr_ovf = 1'b0;
      check("clr_overflow", int'(overflow), 0);
      drain = 1'b1;
      wait_empty();
      check("model_drained", fifo_m.size(), 0);
      // reset mid-debounce with key0 held
      keys = 4'b0001;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("rstA_empty", int'(empty), 1);
      check("rstA_count", int'(count), 0);
      check("rstA_strobe", int'(push_strobe), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      expect_press(0, 1'b0, cyc, 3, 0);
      // reset with two entries queued
      wait_empty();
      drain = 1'b0;
      @(posedge clk);
      #1 keys = 4'b0001;
      repeat_en = 1'b1;
      t0 = cyc;
      p = t0 + D + 3;
      exp_strobe.push_back(p);
      exp_strobe.push_back(p + RD + 1);
      fifo_m.push_back(codes[0]);
      fifo_m.push_back(codes[0]);
      repeat (p + RD + 3 - cyc) @(posedge clk);
      #1 check("rstB_pre_count", int'(count), 2);
      #2 rst_n = 1'b0;
      #1 check("rstB_empty", int'(empty), 1);
      check("rstB_count", int'(count), 0);
      check("rstB_full", int'(full), 0);
      check("rstB_overflow", int'(overflow), 0);
      check("rstB_strobe", int'(push_strobe), 0);
      check("rstB_strobes_seen", exp_strobe.size(), 0);
      fifo_m.delete();
      repeat_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      expect_press(0, 1'b0, cyc, 3, 0);
      check("fresh_count", int'(count), 1);
      drain = 1'b1;
      wait_empty();
      repeat (5) @(posedge clk);
      #1 check("final_strobes_left", exp_strobe.size(), 0);
      check("final_entries_left", fifo_m.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
